// File: rtl/leaf_out_stream_arbiter.sv
// Round-robin arbiter multiplexing NUM_STREAMS ap_vld/ap_ack user streams onto one
// tagged output port, with a one-entry output register and bounded bursts per grant.
module leaf_out_stream_arbiter #(
   parameter int NUM_STREAMS  = 4,
   parameter int ID_BITS      = 2,
   parameter int PAYLOAD_BITS = 32,
   parameter int MAX_BURST    = 4
) (
   input  logic                                clk_user,
   input  logic                                reset,
   input  logic [NUM_STREAMS*PAYLOAD_BITS-1:0] din_user2arb,
   input  logic [NUM_STREAMS-1:0]              vld_user2arb,
   output logic [NUM_STREAMS-1:0]              ack_arb2user,
   output logic [PAYLOAD_BITS-1:0]             dout_arb2interface,
   output logic [ID_BITS-1:0]                  tag_arb2interface,
   output logic                                vld_arb2interface,
   input  logic                                ack_interface2arb,
   output logic [ID_BITS-1:0]                  grant_id,
   output logic                                busy
);
   localparam int CNT_W = $clog2(MAX_BURST + 1);

   typedef enum logic {S_IDLE, S_GRANT} state_t;

   state_t                  state_q, state_d;
   logic [ID_BITS-1:0]      last_grant_q, last_grant_d;
   logic [ID_BITS-1:0]      grant_id_q, grant_id_d;
   logic [CNT_W-1:0]        burst_cnt_q, burst_cnt_d;
   logic                    out_vld_q, out_vld_d;
   logic [PAYLOAD_BITS-1:0] out_data_q, out_data_d;
   logic [ID_BITS-1:0]      out_tag_q, out_tag_d;

   logic                    out_free;
   logic                    in_xfer;
   logic                    grant_vld;
   logic [PAYLOAD_BITS-1:0] grant_data;
   logic                    found;
   logic [ID_BITS-1:0]      pick;

   always_ff @(posedge clk_user or posedge reset) begin
      if (reset) begin
         state_q      <= S_IDLE;
         last_grant_q <= ID_BITS'(NUM_STREAMS - 1);
         grant_id_q   <= '0;
         burst_cnt_q  <= '0;
         out_vld_q    <= 1'b0;
         out_data_q   <= '0;
         out_tag_q    <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         burst_cnt_q  <= burst_cnt_d;
         out_vld_q    <= out_vld_d;
         out_data_q   <= out_data_d;
         out_tag_q    <= out_tag_d;
      end
   end

   // Granted stream's vld/data, plus the round-robin winner: first requester above last_grant, else lowest.
   always_comb begin
      grant_vld  = 1'b0;
      grant_data = '0;
      found      = 1'b0;
      pick       = '0;
      for (int j = 0; j < NUM_STREAMS; j++) begin
         if (grant_id_q == ID_BITS'(j)) begin
            grant_vld  = vld_user2arb[j];
            grant_data = din_user2arb[j*PAYLOAD_BITS +: PAYLOAD_BITS];
         end
      end
      for (int j = 0; j < NUM_STREAMS; j++) begin
         if (!found && vld_user2arb[j] && (j > int'(last_grant_q))) begin
            found = 1'b1;
            pick  = ID_BITS'(j);
         end
      end
      for (int j = 0; j < NUM_STREAMS; j++) begin
         if (!found && vld_user2arb[j]) begin
            found = 1'b1;
            pick  = ID_BITS'(j);
         end
      end
   end

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      burst_cnt_d  = burst_cnt_q;
      case (state_q)
         S_IDLE: begin
            if (|vld_user2arb) begin
               grant_id_d  = pick;
               burst_cnt_d = '0;
               state_d     = S_GRANT;
            end
         end
         S_GRANT: begin
            if (!grant_vld) begin
               state_d      = S_IDLE;
               last_grant_d = grant_id_q;
            end else if (out_free) begin
               burst_cnt_d = burst_cnt_q + CNT_W'(1);
               if (burst_cnt_q == CNT_W'(MAX_BURST - 1)) begin
                  state_d      = S_IDLE;
                  last_grant_d = grant_id_q;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Output register: drain and reload in the same cycle keeps full rate.
   always_comb begin
      out_vld_d  = out_vld_q;
      out_data_d = out_data_q;
      out_tag_d  = out_tag_q;
      if (in_xfer) begin
         out_vld_d  = 1'b1;
         out_data_d = grant_data;
         out_tag_d  = grant_id_q;
      end else if (ack_interface2arb) begin
         out_vld_d = 1'b0;
      end
   end

   always_comb begin
      out_free     = !out_vld_q || ack_interface2arb;
      in_xfer      = (state_q == S_GRANT) && grant_vld && out_free;
      ack_arb2user = '0;
      for (int j = 0; j < NUM_STREAMS; j++) begin
         if (in_xfer && (grant_id_q == ID_BITS'(j))) ack_arb2user[j] = 1'b1;
      end
      busy               = (state_q == S_GRANT);
      grant_id           = grant_id_q;
      vld_arb2interface  = out_vld_q;
      dout_arb2interface = out_data_q;
      tag_arb2interface  = out_tag_q;
   end

endmodule

// File: tb/tb_leaf_out_stream_arbiter.sv
// Randomized and directed bench for leaf_out_stream_arbiter: per-stream sequence
// scoreboard, round-robin winner model, burst bound, fairness and stall-hold checks.
module tb_leaf_out_stream_arbiter;
   localparam int N  = 4;
   localparam int IDB = 2;
   localparam int PB = 32;
   localparam int MB = 4;

   logic            clk = 1'b0;
   logic            reset;
   logic [N*PB-1:0] din_user2arb;
   logic [N-1:0]    vld_user2arb;
   logic [N-1:0]    ack_arb2user;
   logic [PB-1:0]   dout_arb2interface;
   logic [IDB-1:0]  tag_arb2interface;
   logic            vld_arb2interface;
   logic            ack_interface2arb;
   logic [IDB-1:0]  grant_id;
   logic            busy;

   leaf_out_stream_arbiter #(
      .NUM_STREAMS(N), .ID_BITS(IDB), .PAYLOAD_BITS(PB), .MAX_BURST(MB)
   ) dut (
      .clk_user(clk), .reset(reset),
      .din_user2arb(din_user2arb), .vld_user2arb(vld_user2arb),
      .ack_arb2user(ack_arb2user),
      .dout_arb2interface(dout_arb2interface), .tag_arb2interface(tag_arb2interface),
      .vld_arb2interface(vld_arb2interface), .ack_interface2arb(ack_interface2arb),
      .grant_id(grant_id), .busy(busy)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad = 0;

   logic [31:0] base [N];
   int          lim  [N];
   int          sent [N];
   int          rcv  [N];
   bit          en   [N];
   int          wait_m [N];
   int          ack_mode;
   bit          rnd_vld;
   int          cyc;
   int          last_win;
   int          burst_m;
   int          first_in_cyc;
   int          log_tag [$];
   int          log_cyc [$];

   logic [N-1:0] prev_v, prev_a;
   logic         prev_ov, prev_oa, prev_busy;
   logic [31:0]  prev_od;
   logic [1:0]   prev_ot;

   function automatic int rr_pick(logic [N-1:0] m, int last);
      for (int k = 1; k <= N; k++) begin
         int s;
         s = (last + k) % N;
         if (((m >> s) & 1) != 0) return s;
      end
      return -1;
   endfunction

   function automatic bit all_done();
      for (int i = 0; i < N; i++) if (rcv[i] < lim[i]) return 1'b0;
      return 1'b1;
   endfunction

   task automatic clear_model();
      for (int i = 0; i < N; i++) begin
         sent[i] = 0; rcv[i] = 0; lim[i] = 0; en[i] = 1'b0; wait_m[i] = 0;
         base[i] = 32'h0;
      end
      rnd_vld = 1'b0; ack_mode = 0; cyc = 0; last_win = N - 1; burst_m = 0;
      first_in_cyc = -1;
      prev_v = '0; prev_a = '0; prev_ov = 1'b0; prev_oa = 1'b0; prev_busy = 1'b0;
      prev_od = '0; prev_ot = '0;
      log_tag.delete(); log_cyc.delete();
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      repeat (2) @(negedge clk);
      clear_model();
      vld_user2arb = '0;
      reset = 1'b0;
   endtask

   // One clock: drive at negedge, sample 1ns later, account transfers at posedge.
   task automatic cycle();
      logic [N-1:0] v, a;
      logic         ov, oa, b;
      logic [31:0]  od;
      logic [1:0]   ot, gid;
      int           w;
      for (int i = 0; i < N; i++) begin
         if (rnd_vld && !(prev_v[i] && !prev_a[i])) en[i] = ($urandom_range(0, 3) != 0);
         vld_user2arb[i] = en[i] && (sent[i] < lim[i]);
         din_user2arb[i*PB +: PB] = base[i] + sent[i];
      end
      case (ack_mode)
         0:       ack_interface2arb = 1'b1;
         1:       ack_interface2arb = ((cyc % 4) == 0) || ((cyc % 4) == 3);
         default: ack_interface2arb = 1'($urandom_range(0, 1));
      endcase
      #1;
      v = vld_user2arb; a = ack_arb2user; ov = vld_arb2interface; oa = ack_interface2arb;
      od = dout_arb2interface; ot = tag_arb2interface; b = busy; gid = grant_id;

      total++;
      if ($countones(a) > 1) begin
         bad++; $display("FAIL ack_onehot: got %b want at most one bit", a);
      end
      total++;
      if ((a & ~v) != '0) begin
         bad++; $display("FAIL ack_without_vld: ack %b vld %b", a, v);
      end
      if (ov && !oa) begin
         total++;
         if (a != '0) begin
            bad++; $display("FAIL ack_while_full: got %b want 0000", a);
         end
      end
      if (prev_ov && !prev_oa) begin
         total++;
         if (!ov || od !== prev_od || ot !== prev_ot) begin
            bad++;
            $display("FAIL stall_hold: got vld=%b d=%h t=%0d want vld=1 d=%h t=%0d",
                     ov, od, ot, prev_od, prev_ot);
         end
      end
      if (b && !prev_busy) begin
         w = rr_pick(prev_v, last_win);
         total++;
         if (int'(gid) != w) begin
            bad++; $display("FAIL grant_pick: got %0d want %0d", gid, w);
         end
         if (w < 0) w = int'(gid);
         for (int i = 0; i < N; i++) begin
            if (i == w) wait_m[i] = 0;
            else if (prev_v[i]) begin
               wait_m[i]++;
               total++;
               if (wait_m[i] > N - 1) begin
                  bad++; $display("FAIL fairness: stream %0d waited %0d grants want <= %0d",
                                  i, wait_m[i], N - 1);
               end
            end else wait_m[i] = 0;
         end
         last_win = w;
         burst_m = 0;
      end

      @(posedge clk);
      if (ov && oa) begin
         total++;
         if (rcv[ot] >= sent[ot] || od !== base[ot] + rcv[ot]) begin
            bad++;
            $display("FAIL out_order: tag %0d got %h want %h (sent %0d)",
                     ot, od, base[ot] + rcv[ot], sent[ot]);
         end
         rcv[ot]++;
         log_tag.push_back(int'(ot));
         log_cyc.push_back(cyc);
      end
      for (int i = 0; i < N; i++) begin
         if (v[i] && a[i]) begin
            sent[i]++;
            burst_m++;
            if (first_in_cyc < 0) first_in_cyc = cyc;
            total++;
            if (burst_m > MB) begin
               bad++; $display("FAIL burst_len: got %0d want <= %0d", burst_m, MB);
            end
         end
      end
      prev_v = v; prev_a = a; prev_ov = ov; prev_oa = oa; prev_od = od; prev_ot = ot;
      prev_busy = b;
      cyc++;
      @(negedge clk);
   endtask

   task automatic run_until_done(input int budget, input string name);
      for (int k = 0; k < budget && !all_done(); k++) cycle();
      for (int i = 0; i < N; i++) begin
         total++;
         if (rcv[i] != lim[i]) begin
            bad++; $display("FAIL %s_count: stream %0d got %0d want %0d", name, i, rcv[i], lim[i]);
         end
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      vld_user2arb = '1;
      ack_interface2arb = 1'b1;
      din_user2arb = '1;
      @(negedge clk);
      #1;
      total++;
      if (vld_arb2interface !== 1'b0 || dout_arb2interface !== '0 || tag_arb2interface !== '0 ||
          ack_arb2user !== '0 || busy !== 1'b0 || grant_id !== '0) begin
         bad++;
         $display("FAIL reset_state: vld=%b d=%h t=%0d ack=%b busy=%b gid=%0d want all 0",
                  vld_arb2interface, dout_arb2interface, tag_arb2interface, ack_arb2user,
                  busy, grant_id);
      end
      apply_reset();
   endtask

   task automatic test_single_stream();
      apply_reset();
      base[0] = 32'hA0; lim[0] = 6; en[0] = 1'b1;
      run_until_done(40, "single");
      total++;
      if (first_in_cyc != 1) begin
         bad++; $display("FAIL first_ack_cycle: got %0d want 1", first_in_cyc);
      end
      total++;
      if (log_cyc.size() != 6) begin
         bad++; $display("FAIL single_words: got %0d want 6", log_cyc.size());
      end else begin
         for (int k = 1; k < 6; k++) begin
            total++;
            if (log_cyc[k] - log_cyc[k-1] != ((k == 4) ? 2 : 1)) begin
               bad++; $display("FAIL single_gap: word %0d gap got %0d want %0d",
                               k, log_cyc[k] - log_cyc[k-1], (k == 4) ? 2 : 1);
            end
         end
      end
   endtask

   task automatic test_round_robin();
      apply_reset();
      for (int i = 0; i < N; i++) begin
         base[i] = 32'h1000 * (i + 1); lim[i] = 8; en[i] = 1'b1;
      end
      run_until_done(100, "rr");
      for (int k = 0; k < 32 && k < log_tag.size(); k++) begin
         total++;
         if (log_tag[k] != (k / 4) % 4) begin
            bad++; $display("FAIL rr_tag: word %0d got %0d want %0d", k, log_tag[k], (k / 4) % 4);
         end
         if (k > 0) begin
            total++;
            if (log_cyc[k] - log_cyc[k-1] != ((k % 4 == 0) ? 2 : 1)) begin
               bad++; $display("FAIL rr_gap: word %0d gap got %0d want %0d",
                               k, log_cyc[k] - log_cyc[k-1], (k % 4 == 0) ? 2 : 1);
            end
         end
      end
   endtask

   task automatic test_stall();
      apply_reset();
      base[2] = 32'hC0; lim[2] = 8; en[2] = 1'b1; ack_mode = 1;
      run_until_done(80, "stall");
   endtask

   task automatic test_release();
      int exp_tags [7] = '{1, 1, 3, 3, 3, 0, 0};
      apply_reset();
      base[0] = 32'hD00; base[1] = 32'hD10; base[3] = 32'hD30;
      lim[0] = 2; lim[1] = 2; lim[3] = 3;
      en[1] = 1'b1; en[3] = 1'b1;
      for (int k = 0; k < 60 && !all_done(); k++) begin
         if (sent[1] >= 2) en[0] = 1'b1;
         cycle();
      end
      total++;
      if (log_tag.size() != 7) begin
         bad++; $display("FAIL release_words: got %0d want 7", log_tag.size());
      end else begin
         for (int k = 0; k < 7; k++) begin
            total++;
            if (log_tag[k] != exp_tags[k]) begin
               bad++; $display("FAIL release_tag: word %0d got %0d want %0d", k, log_tag[k], exp_tags[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid_burst();
      int k;
      apply_reset();
      for (int i = 0; i < N; i++) begin
         base[i] = 32'hE000 + 32'h100 * i; lim[i] = 8; en[i] = 1'b1;
      end
      ack_mode = 2;
      k = 0;
      while (!(prev_ov && !prev_oa) && k < 40) begin
         cycle();
         k++;
      end
      total++;
      if (!(prev_ov && !prev_oa)) begin
         bad++; $display("FAIL midburst_setup: stalled word not seen within 40 cycles");
      end
      #2;
      reset = 1'b1;
      #1;
      total++;
      if (vld_arb2interface !== 1'b0 || dout_arb2interface !== '0 || tag_arb2interface !== '0 ||
          ack_arb2user !== '0 || busy !== 1'b0) begin
         bad++;
         $display("FAIL midburst_reset: vld=%b d=%h t=%0d ack=%b busy=%b want all 0",
                  vld_arb2interface, dout_arb2interface, tag_arb2interface, ack_arb2user, busy);
      end
      apply_reset();
      for (int i = 0; i < N; i++) begin
         base[i] = 32'hF000 + 32'h100 * i; lim[i] = 4; en[i] = 1'b1;
      end
      run_until_done(60, "after_reset");
      total++;
      if (log_tag.size() == 0 || log_tag[0] != 0) begin
         bad++; $display("FAIL restart_stream0: got %0d want 0",
                         (log_tag.size() == 0) ? -1 : log_tag[0]);
      end
   endtask

   task automatic test_random();
      apply_reset();
      for (int i = 0; i < N; i++) begin
         base[i] = 32'(i) << 24; lim[i] = 1000000;
      end
      rnd_vld = 1'b1; ack_mode = 2;
      repeat (10000) cycle();
      rnd_vld = 1'b0; ack_mode = 0;
      for (int i = 0; i < N; i++) en[i] = 1'b0;
      repeat (10) cycle();
      for (int i = 0; i < N; i++) begin
         total++;
         if (rcv[i] != sent[i] || sent[i] == 0) begin
            bad++; $display("FAIL random_count: stream %0d got %0d want %0d (nonzero)",
                            i, rcv[i], sent[i]);
         end
      end
   endtask

   initial begin
      reset = 1'b1;
      vld_user2arb = '0;
      din_user2arb = '0;
      ack_interface2arb = 1'b0;
      clear_model();
      test_reset();
      test_single_stream();
      test_round_robin();
      test_stall();
      test_release();
      test_reset_mid_burst();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
